// File: rtl/time_set_ctrl.sv
// Digital clock sequencer: 1 Hz tick and sec->min->hour carry in RUN, plus key-driven
// set mode with debounced keys, field select, auto-repeat, field blink and seconds clear.
module time_set_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000,
    parameter int BLINK_CYCLES    = 12_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       tick_1hz,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       clr_sec,
    output logic       set_active,
    output logic [1:0] state,
    output logic       blank_hour,
    output logic       blank_min,
    output logic       blank_sec
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int PRE_W   = $clog2(CLK_HZ + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int BL_W    = $clog2(BLINK_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [BL_W-1:0]  BL_LAST   = BL_W'(BLINK_CYCLES - 1);

    // Key bit 0 = mode, bit 1 = inc; synchronizers hold raw (active-low) levels.
    logic [1:0]       sync1_r, sync2_r, synced_s;
    logic [1:0]       db_level_r, db_prev_r, press_r;
    logic [DB_W-1:0]  db_cnt_r [2];

    state_t           state_r, next_state_s;
    logic [PRE_W-1:0] pre_r, pre_next_s;
    logic [REP_W-1:0] rep_cnt_r, rep_cnt_next_s;
    logic             rep_active_r, rep_active_next_s, rep_first_r, rep_first_next_s;
    logic [BL_W-1:0]  blink_cnt_r, blink_cnt_next_s;
    logic             blink_r, blink_next_s;
    logic             tick_r, inc_sec_r, inc_min_r, inc_hour_r, clr_sec_r, set_active_r;
    logic             blank_hour_r, blank_min_r, blank_sec_r;

    logic mode_ev_s, inc_ev_s, inc_db_s, in_adj_s, run_s, tick_s;
    logic rep_hold_s, rep_fire_s, key_hour_s, key_min_s, key_clr_s, blink_restart_s;

    assign synced_s  = ~sync2_r;
    assign mode_ev_s = press_r[0];
    assign inc_ev_s  = press_r[1] & ~press_r[0];
    assign inc_db_s  = db_level_r[1];
    assign in_adj_s  = (state_r == ST_SET_HOUR) || (state_r == ST_SET_MIN);
    assign run_s     = (state_r == ST_RUN) && !mode_ev_s;
    assign tick_s    = run_s && (pre_r == PRE_LAST);

    assign rep_hold_s = rep_active_r && inc_db_s && in_adj_s && !mode_ev_s;
    assign rep_fire_s = rep_hold_s && (rep_first_r ? (rep_cnt_r == HOLD_LAST) : (rep_cnt_r == REP_LAST));

    // Key synchronizers, debounce counters and press-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r    <= 2'b11;
            sync2_r    <= 2'b11;
            db_level_r <= 2'b00;
            db_prev_r  <= 2'b00;
            press_r    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= DB_W'(0);
            end
        end else begin
            sync1_r   <= {key_inc_n, key_mode_n};
            sync2_r   <= sync1_r;
            db_prev_r <= db_level_r;
            press_r   <= db_level_r & ~db_prev_r;
            for (int i = 0; i < 2; i++) begin
                if (synced_s[i] == db_level_r[i]) begin
                    db_cnt_r[i] <= DB_W'(0);
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_level_r[i] <= synced_s[i];
                    db_cnt_r[i]   <= DB_W'(0);
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and key-driven field pulses; a mode press swallows a same-cycle inc press.
    always_comb begin
        next_state_s = state_r;
        key_hour_s   = 1'b0;
        key_min_s    = 1'b0;
        key_clr_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mode_ev_s) next_state_s = ST_SET_HOUR;
                else           next_state_s = ST_RUN;
            end
            ST_SET_HOUR: begin
                if (mode_ev_s) begin
                    next_state_s = ST_SET_MIN;
                end else begin
                    next_state_s = ST_SET_HOUR;
                    key_hour_s   = inc_ev_s | rep_fire_s;
                end
            end
            ST_SET_MIN: begin
                if (mode_ev_s) begin
                    next_state_s = ST_SET_SEC;
                end else begin
                    next_state_s = ST_SET_MIN;
                    key_min_s    = inc_ev_s | rep_fire_s;
                end
            end
            ST_SET_SEC: begin
                if (mode_ev_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_SET_SEC;
                    key_clr_s    = inc_ev_s;
                end
            end
            default: next_state_s = ST_RUN;
        endcase
    end

    // Prescaler runs only in RUN and sits at zero otherwise, so re-entry starts a full second.
    always_comb begin
        pre_next_s = PRE_W'(0);
        if (!run_s) begin
            pre_next_s = PRE_W'(0);
        end else if (pre_r == PRE_LAST) begin
            pre_next_s = PRE_W'(0);
        end else begin
            pre_next_s = pre_r + PRE_W'(1);
        end
    end

    // Auto-repeat: first step after the hold delay, then at the repeat period while held.
    always_comb begin
        rep_active_next_s = 1'b0;
        rep_first_next_s  = 1'b0;
        rep_cnt_next_s    = REP_W'(0);
        if (inc_ev_s && in_adj_s) begin
            rep_active_next_s = 1'b1;
            rep_first_next_s  = 1'b1;
        end else if (rep_fire_s) begin
            rep_active_next_s = 1'b1;
            rep_first_next_s  = 1'b0;
        end else if (rep_hold_s) begin
            rep_active_next_s = 1'b1;
            rep_first_next_s  = rep_first_r;
            rep_cnt_next_s    = rep_cnt_r + REP_W'(1);
        end else begin
            rep_active_next_s = 1'b0;
        end
    end

    assign blink_restart_s = (next_state_s != state_r) || key_hour_s || key_min_s || key_clr_s;

    // Blink phase restarts visible on state entry and on every step it issues.
    always_comb begin
        blink_cnt_next_s = BL_W'(0);
        blink_next_s     = 1'b0;
        if ((next_state_s == ST_RUN) || blink_restart_s) begin
            blink_next_s = 1'b0;
        end else if (blink_cnt_r == BL_LAST) begin
            blink_next_s = ~blink_r;
        end else begin
            blink_cnt_next_s = blink_cnt_r + BL_W'(1);
            blink_next_s     = blink_r;
        end
    end

    // Datapath counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_r        <= PRE_W'(0);
            rep_cnt_r    <= REP_W'(0);
            rep_active_r <= 1'b0;
            rep_first_r  <= 1'b0;
            blink_cnt_r  <= BL_W'(0);
            blink_r      <= 1'b0;
            tick_r       <= 1'b0;
            inc_sec_r    <= 1'b0;
            inc_min_r    <= 1'b0;
            inc_hour_r   <= 1'b0;
            clr_sec_r    <= 1'b0;
            set_active_r <= 1'b0;
            blank_hour_r <= 1'b0;
            blank_min_r  <= 1'b0;
            blank_sec_r  <= 1'b0;
        end else begin
            pre_r        <= pre_next_s;
            rep_cnt_r    <= rep_cnt_next_s;
            rep_active_r <= rep_active_next_s;
            rep_first_r  <= rep_first_next_s;
            blink_cnt_r  <= blink_cnt_next_s;
            blink_r      <= blink_next_s;
            tick_r       <= tick_s;
            inc_sec_r    <= tick_s;
            inc_min_r    <= (tick_s && sec_max) || key_min_s;
            inc_hour_r   <= (tick_s && sec_max && min_max) || key_hour_s;
            clr_sec_r    <= key_clr_s;
            set_active_r <= (next_state_s != ST_RUN);
            blank_hour_r <= blink_next_s && (next_state_s == ST_SET_HOUR);
            blank_min_r  <= blink_next_s && (next_state_s == ST_SET_MIN);
            blank_sec_r  <= blink_next_s && (next_state_s == ST_SET_SEC);
        end
    end

    assign tick_1hz   = tick_r;
    assign inc_sec    = inc_sec_r;
    assign inc_min    = inc_min_r;
    assign inc_hour   = inc_hour_r;
    assign clr_sec    = clr_sec_r;
    assign set_active = set_active_r;
    assign state      = state_r;
    assign blank_hour = blank_hour_r;
    assign blank_min  = blank_min_r;
    assign blank_sec  = blank_sec_r;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Sequencing controller for the digital clock's second, minute and hour counters. It generates the 1 Hz timekeeping tick and the per-field increment pulses in run mode, including the sec→min→hour carry chain. It also implements the key-driven set mode: debounced keys, field selection, auto-repeat, field blink and second clear. It sits between the board keys and the `counter`-based field blocks, and drives their clock enables, `set` and blanking.

## Interface

**Parameters**
- `CLK_HZ`, 50_000_000: clock cycles per 1 Hz tick.
- `DEBOUNCE_CYCLES`, 1_000_000: stable-sample count required to accept a key level change.
- `HOLD_CYCLES`, 25_000_000: press-to-first-repeat delay.
- `REPEAT_CYCLES`, 5_000_000: auto-repeat period.
- `BLINK_CYCLES`, 12_500_000: half-period of the selected-field blink.

**Ports**
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `key_mode_n` in 1: raw mode key, active-low, asynchronous.
- `key_inc_n` in 1: raw increment key, active-low, asynchronous.
- `sec_max` in 1: seconds counter at terminal value (59).
- `min_max` in 1: minutes counter at terminal value (59).
- `tick_1hz` out 1: one-cycle pulse every `CLK_HZ` cycles, RUN only.
- `inc_sec` out 1: seconds increment pulse.
- `inc_min` out 1: minutes increment pulse.
- `inc_hour` out 1: hours increment pulse.
- `clr_sec` out 1: one-cycle seconds synchronous clear.
- `set_active` out 1: high in any SET state.
- `state` out 2: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC.
- `blank_hour` out 1: display blank for the hour field.
- `blank_min` out 1: display blank for the minute field.
- `blank_sec` out 1: display blank for the seconds field.

## Operation

- **Key front end (per key)**
  - 2-FF synchronizer, then inversion.
  - Debounce counter: the debounced level takes the synced level after `DEBOUNCE_CYCLES` consecutive equal samples. Any differing sample restarts the count.
  - A press event is a one-cycle pulse on the debounced 0→1 transition. Releases produce no event.
- **FSM**
  - A `mode` press advances RUN → SET_HOUR → SET_MIN → SET_SEC → RUN.
  - A `mode` press and an `inc` press in the same cycle: `mode` wins and the `inc` event is discarded.
- **RUN**
  - Free-running prescaler from 0 to `CLK_HZ`-1.
  - `tick_1hz` pulses on wrap.
  - `inc_sec` = tick.
  - `inc_min` = tick & `sec_max`.
  - `inc_hour` = tick & `sec_max` & `min_max`.
  - `inc` key events are ignored.
- **SET states**
  - Prescaler held at 0, so no ticks.
  - SET_HOUR: an `inc` event pulses `inc_hour` only. No carry; the hour counter wraps itself.
  - SET_MIN: an `inc` event pulses `inc_min` only. Never `inc_hour`, even when `min_max` is high.
  - SET_SEC: an `inc` event pulses `clr_sec`. There is no seconds increment and no auto-repeat.
- **Auto-repeat** (SET_HOUR and SET_MIN only)
  - While `inc` stays debounced-held, an extra increment fires `HOLD_CYCLES` after the press event, then every `REPEAT_CYCLES`.
  - Release or a state change stops repeating immediately.
- **Blink**
  - The selected field's blank toggles every `BLINK_CYCLES`.
  - The blink counter restarts with the field visible (blank=0) on state entry and on every increment or clear it issues.
  - Non-selected fields and all fields in RUN: blank=0.
- **Re-entering RUN**
  - The prescaler starts from 0.
  - The first `tick_1hz` occurs `CLK_HZ` cycles after the transition.

## Timing

- All outputs are registered.
- **Reset values:**
  - `state` = RUN.
  - All pulses, blanks and `set_active` = 0.
  - Prescaler, debounce, repeat and blink counters = 0.
  - Debounced key levels = released.
  - Synchronizers = released.
- **Reset behaviour:**
  - Reset asserted in any state returns to RUN on the next edge.
  - No pulse is emitted on the reset cycle.
  - A key held through reset produces a press event only after reset deasserts and `DEBOUNCE_CYCLES` of stable samples elapse.
- **Press latency:** with the raw key held from edge k, the press event is internal at edge k+2+`DEBOUNCE_CYCLES`. The resulting output pulse (`inc_*` or `clr_sec`) and `state` update are visible one cycle later.
- **Tick latency:** `tick_1hz` and the `inc_*` pulses are high for exactly one cycle, in the same cycle, following the prescaler value `CLK_HZ`-1.
- **Carry inputs:** `sec_max` and `min_max` are sampled in the cycle the prescaler equals `CLK_HZ`-1.
- **Pulse mutual exclusion:** at most one of `inc_hour`/`inc_min`/`clr_sec` is driven by key logic per cycle. RUN carry pulses may coincide with each other, as defined above.
- **Repeat timing:** the first repeat pulse comes exactly `HOLD_CYCLES` after the press pulse. Subsequent repeat pulses are spaced exactly `REPEAT_CYCLES`.

## Test plan

Bench parameters: `CLK_HZ`=10, `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=5, `BLINK_CYCLES`=8.

1. **Reset and run ticks:** reset for 3 cycles, `sec_max`=`min_max`=0 → `tick_1hz`/`inc_sec` pulse every 10 cycles, first on cycle 10 after release; `inc_min`=`inc_hour`=0.
2. **Carry chain:** hold `sec_max`=1, `min_max`=1 across a tick → `inc_sec`, `inc_min` and `inc_hour` high in the same single cycle; with `min_max`=0, only `inc_sec` and `inc_min` pulse.
3. **Debounce:** `key_mode_n` bounces low/high for 3-cycle bursts, then holds low → no early event; `state` becomes 1 exactly 4+3 cycles after the stable low begins; exactly one transition.
4. **Set-hour auto-repeat:** in SET_HOUR, hold `key_inc_n` low for 40 cycles → `inc_hour` pulses at press, +20, +25, +30, +35; no `inc_min`/`inc_sec`; `blank_hour` reset to 0 at each pulse.
5. **SET_SEC clear and exit:** advance to SET_SEC, press inc → one `clr_sec` pulse with no repeat while held; press mode → `state`=0, `set_active`=0, next `tick_1hz` exactly 10 cycles later.
6. **Simultaneous keys and mid-op reset:** press both keys together in SET_MIN → `state`=3, no `inc_min`; assert reset mid-blink → `state`=0, all blanks and pulses 0 on the next edge.
